debit_pin_lock: RTL and testbench
=================================

Name: debit_pin_lock

Overview:
- Parametrised successor to the debit PIN FSM: accepts PIN_LEN digits from NUM_SWITCHES one-hot switches and compares them to a PASSKEY parameter.
- Adds over the previous generation: generic switch count and PIN length, rejection of invalid (non-one-hot) digits, a failed-attempt counter, and a LOCKED state.
- Sits between the switch/button debouncers and the status LEDs.

Parameters:
- NUM_SWITCHES, 4, number of digit switches; must be ≥2. DIGIT_W = $clog2(NUM_SWITCHES).
- PIN_LEN, 4, digits per PIN; must be ≥1.
- PASSKEY, 8'b11_10_01_00, encoded PIN of width PIN_LEN*DIGIT_W; first-entered digit in the MSBs.
- MAX_ATTEMPTS, 3, consecutive mismatches that cause LOCKED; must be ≥1.
- RESULT_HOLD, 4, cycles CORRECT/INCORRECT are held before returning to IDLE; must be ≥1.
- LOCKOUT_CYCLES, 1000, LOCKED duration; used only with DEBIT_PIN_LOCKOUT_TIMER_EN.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- digit_switches  in  NUM_SWITCHES  switch levels; valid digit = exactly one bit set.
- submit  in  1  level input; its rising edge enters a digit.
- waiting  out  1  high in IDLE and ENTRY.
- correct  out  1  high in CORRECT.
- incorrect  out  1  high in INCORRECT.
- locked  out  1  high in LOCKED.
- bug  out  1  one-cycle pulse when an entry is rejected as invalid.
- digit_count  out  $clog2(PIN_LEN+1)  digits accepted in the current attempt.
- attempts  out  $clog2(MAX_ATTEMPTS+1)  consecutive mismatches so far.

Behaviour:
- Reset (async assert, sync release to clk):
  - state = IDLE; shift register, digit_count and attempts = 0; bug = 0.
  - Outputs: waiting = 1, all other status outputs = 0.
  - submit_q resets to 1, so a submit held high through reset release is not treated as an edge.
- Submit edge: sub_edge = submit & ~submit_q; submit_q <= submit every cycle. A held submit enters exactly one digit.
- Digit acceptance (on sub_edge, only in IDLE or ENTRY):
  - If digit_switches is one-hot: shift register <= {sr[..], index of set bit}; digit_count += 1.
  - If zero or multi-hot: no shift, no count change; bug = 1 on the next cycle only.
  - In all other states sub_edge is ignored and bug stays 0.
- State transitions:
  - IDLE → ENTRY on the first accepted digit.
  - ENTRY → CHECK on the same edge that accepts digit PIN_LEN.
  - CHECK lasts exactly 1 cycle:
    - match → CORRECT; attempts = 0.
    - mismatch → attempts += 1, then INCORRECT if attempts < MAX_ATTEMPTS, else LOCKED.
  - CORRECT/INCORRECT hold for RESULT_HOLD cycles, then → IDLE; shift register and digit_count clear on that transition.
  - LOCKED: shift register and digit_count clear on entry.
- Latency: last digit's edge E → CHECK after E → correct/incorrect/locked asserted after edge E+1.
- Outputs are Moore-decoded from the state register. bug, digit_count and attempts are registered.
- attempts saturates at MAX_ATTEMPTS and never wraps.
- Reset asserted mid-entry or in LOCKED returns immediately to reset values.

Optional Feature:
- Macro DEBIT_PIN_LOCKOUT_TIMER_EN.
- Defined: a down-counter loads LOCKOUT_CYCLES-1 on entering LOCKED. At 0, state → IDLE and attempts clears. locked is high for exactly LOCKOUT_CYCLES cycles.
- Undefined: LOCKED is exited only by reset; no timer logic is synthesised.

Decomposition:
- Package debit_pin_pkg holds:
  - state enum {IDLE, ENTRY, CHECK, CORRECT, INCORRECT, LOCKED};
  - function onehot_index, returning the index plus a valid flag;
  - function is_onehot.
- One sub-module, pin_entry_sr, instance name pinchk:
  - contents: submit edge detect, one-hot check, shift register (signal name password), digit_count;
  - outputs: accept and reject pulses to the FSM.

Test Plan:
- Correct PIN with defaults: submit 1000, 0100, 0010, 0001 → pinchk.password = 8'b11100100; correct = 1 one cycle after the 4th edge, held 4 cycles; attempts = 0; then waiting = 1.
- Invalid digits: submit 0000, then 1100 → bug pulses 1 cycle each, digit_count stays 0, state stays IDLE; a following 1000 → digit_count = 1.
- Held submit: submit high for 10 cycles with 1000 → digit_count = 1 only.
- Lockout: 3 wrong PINs (0001 ×4 each) → incorrect twice with attempts = 1 then 2; 3rd attempt → locked = 1, attempts = 3, further submits ignored. With the macro: locked drops after exactly 1000 cycles and attempts = 0. Without it: locked stays high until reset.
- Reset mid-entry: 2 digits entered, reset pulsed low with submit held high → digit_count = 0, waiting = 1, no digit accepted after release until submit falls and rises again.
- Wrong then correct: 1 wrong PIN (attempts = 1), then the correct PIN → correct = 1, attempts = 0.

Source files
------------

// File: rtl/debit_pin_pkg.sv
// Shared types and helpers for the debit PIN lock: FSM state encoding and one-hot digit decoding.
// Helpers take a zero-extended switch vector of up to MAX_SW bits.
package debit_pin_pkg;

    localparam int MAX_SW    = 64;
    localparam int MAX_IDX_W = 6;

    typedef enum logic [2:0] {
        IDLE,
        ENTRY,
        CHECK,
        CORRECT,
        INCORRECT,
        LOCKED
    } state_e;

    typedef struct packed {
        logic                 vld;
        logic [MAX_IDX_W-1:0] idx;
    } onehot_t;

    function automatic logic is_onehot(input logic [MAX_SW-1:0] v);
        return (v != '0) && ((v & (v - MAX_SW'(1))) == '0);
    endfunction

    function automatic onehot_t onehot_index(input logic [MAX_SW-1:0] v);
        onehot_t r;
        r.vld = is_onehot(v);
        r.idx = '0;
        for (int i = 0; i < MAX_SW; i++) begin
            if (v[i]) r.idx = MAX_IDX_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/pin_entry_sr.sv
// Digit entry path: submit rising-edge detect, one-hot validation, PIN shift register and digit count.
// accept_o/reject_o are combinational single-cycle pulses; no backpressure (FSM gates via enable_i).
module pin_entry_sr
    import debit_pin_pkg::*;
#(
    parameter int NUM_SWITCHES = 4,
    parameter int PIN_LEN      = 4,
    localparam int DIGIT_W     = $clog2(NUM_SWITCHES),
    localparam int PW          = PIN_LEN * DIGIT_W,
    localparam int CNT_W       = $clog2(PIN_LEN + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_SWITCHES-1:0] digit_switches,
    input  logic                    submit,
    input  logic                    enable_i,
    input  logic                    clear_i,
    output logic                    accept_o,
    output logic                    reject_o,
    output logic [PW-1:0]           password_o,
    output logic [CNT_W-1:0]        digit_count_o
);

    logic             submit_q;
    logic             sub_edge;
    onehot_t          oh;
    logic [PW-1:0]    password;
    logic [CNT_W-1:0] digit_count_q;
    logic [CNT_W-1:0] digit_count_d;
    logic [PW-1:0]    password_d;

    assign sub_edge = submit & ~submit_q;
    assign oh       = onehot_index(MAX_SW'(digit_switches));
    assign accept_o = sub_edge & enable_i & oh.vld;
    assign reject_o = sub_edge & enable_i & ~oh.vld;

    always_comb begin
        password_d    = password;
        digit_count_d = digit_count_q;
        if (clear_i) begin
            password_d    = '0;
            digit_count_d = '0;
        end else if (accept_o) begin
            password_d    = (password << DIGIT_W) | PW'(oh.idx[DIGIT_W-1:0]);
            digit_count_d = digit_count_q + CNT_W'(1);
        end
    end

    // submit_q resets high so a submit held through reset release is not an edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            submit_q      <= 1'b1;
            password      <= '0;
            digit_count_q <= '0;
        end else begin
            submit_q      <= submit;
            password      <= password_d;
            digit_count_q <= digit_count_d;
        end
    end

    assign password_o    = password;
    assign digit_count_o = digit_count_q;

endmodule

// File: rtl/debit_pin_lock.sv
// Debit PIN lock FSM: collects PIN_LEN one-hot digits, checks against PASSKEY, locks after MAX_ATTEMPTS misses.
// Result visible one cycle after the last digit's edge; DEBIT_PIN_LOCKOUT_TIMER_EN adds a timed LOCKED exit.
module debit_pin_lock
    import debit_pin_pkg::*;
#(
    parameter int NUM_SWITCHES   = 4,
    parameter int PIN_LEN        = 4,
    localparam int DIGIT_W       = $clog2(NUM_SWITCHES),
    parameter logic [PIN_LEN*DIGIT_W-1:0] PASSKEY = 8'b11_10_01_00,
    parameter int MAX_ATTEMPTS   = 3,
    parameter int RESULT_HOLD    = 4,
    parameter int LOCKOUT_CYCLES = 1000,
    localparam int CNT_W         = $clog2(PIN_LEN + 1),
    localparam int AW            = $clog2(MAX_ATTEMPTS + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_SWITCHES-1:0] digit_switches,
    input  logic                    submit,
    output logic                    waiting,
    output logic                    correct,
    output logic                    incorrect,
    output logic                    locked,
    output logic                    bug,
    output logic [CNT_W-1:0]        digit_count,
    output logic [AW-1:0]           attempts
);

    localparam int PW = PIN_LEN * DIGIT_W;
    localparam int HW = $clog2(RESULT_HOLD + 1);

    state_e            state_q, state_d;
    logic [AW-1:0]     attempts_q, attempts_d, attempts_inc;
    logic [HW-1:0]     hold_q, hold_d;
    logic              bug_q;
    logic              accept, reject, clear, entry_en, last_digit;
    logic [PW-1:0]     password;

`ifdef DEBIT_PIN_LOCKOUT_TIMER_EN
    localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
    logic [LW-1:0]     lock_q, lock_d;
`endif

    assign entry_en = (state_q == IDLE) || (state_q == ENTRY);

    pin_entry_sr #(
        .NUM_SWITCHES (NUM_SWITCHES),
        .PIN_LEN      (PIN_LEN)
    ) pinchk (
        .clk            (clk),
        .reset          (reset),
        .digit_switches (digit_switches),
        .submit         (submit),
        .enable_i       (entry_en),
        .clear_i        (clear),
        .accept_o       (accept),
        .reject_o       (reject),
        .password_o     (password),
        .digit_count_o  (digit_count)
    );

    assign last_digit   = (digit_count == CNT_W'(PIN_LEN - 1));
    assign attempts_inc = (attempts_q == AW'(MAX_ATTEMPTS)) ? attempts_q : attempts_q + AW'(1);

    always_comb begin
        state_d    = state_q;
        attempts_d = attempts_q;
        hold_d     = hold_q;
        clear      = 1'b0;
`ifdef DEBIT_PIN_LOCKOUT_TIMER_EN
        lock_d     = lock_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = last_digit ? CHECK : ENTRY;
            end
            ENTRY: begin
                if (accept && last_digit) state_d = CHECK;
            end
            CHECK: begin
                if (password == PASSKEY) begin
                    state_d    = CORRECT;
                    attempts_d = '0;
                    hold_d     = HW'(RESULT_HOLD - 1);
                end else if (attempts_inc >= AW'(MAX_ATTEMPTS)) begin
                    state_d    = LOCKED;
                    attempts_d = attempts_inc;
                    clear      = 1'b1;
`ifdef DEBIT_PIN_LOCKOUT_TIMER_EN
                    lock_d     = LW'(LOCKOUT_CYCLES - 1);
`endif
                end else begin
                    state_d    = INCORRECT;
                    attempts_d = attempts_inc;
                    hold_d     = HW'(RESULT_HOLD - 1);
                end
            end
            CORRECT, INCORRECT: begin
                if (hold_q == '0) begin
                    state_d = IDLE;
                    clear   = 1'b1;
                end else begin
                    hold_d = hold_q - HW'(1);
                end
            end
            LOCKED: begin
`ifdef DEBIT_PIN_LOCKOUT_TIMER_EN
                if (lock_q == '0) begin
                    state_d    = IDLE;
                    attempts_d = '0;
                end else begin
                    lock_d = lock_q - LW'(1);
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            attempts_q <= '0;
            hold_q     <= '0;
            bug_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            attempts_q <= attempts_d;
            hold_q     <= hold_d;
            bug_q      <= reject;
        end
    end

`ifdef DEBIT_PIN_LOCKOUT_TIMER_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) lock_q <= '0;
        else        lock_q <= lock_d;
    end
`endif

    assign waiting   = (state_q == IDLE) || (state_q == ENTRY);
    assign correct   = (state_q == CORRECT);
    assign incorrect = (state_q == INCORRECT);
    assign locked    = (state_q == LOCKED);
    assign bug       = bug_q;
    assign attempts  = attempts_q;

endmodule

// File: tb/tb_debit_pin_lock.sv
// Directed bench for debit_pin_lock with default parameters; checks against hand-computed values.
module tb_debit_pin_lock;

    logic       clk;
    logic       reset;
    logic [3:0] digit_switches;
    logic       submit;
    logic       waiting, correct, incorrect, locked, bug;
    logic [2:0] digit_count;
    logic [1:0] attempts;

    int   n_checks;
    int   n_fail;
    logic bug_after;
    int   lock_cycles;

    debit_pin_lock dut (
        .clk            (clk),
        .reset          (reset),
        .digit_switches (digit_switches),
        .submit         (submit),
        .waiting        (waiting),
        .correct        (correct),
        .incorrect      (incorrect),
        .locked         (locked),
        .bug            (bug),
        .digit_count    (digit_count),
        .attempts       (attempts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    // one rising submit edge with the given switches; bug_after samples the cycle after the edge
    task automatic press(input logic [3:0] sw);
        digit_switches = sw;
        submit         = 1'b1;
        step();
        bug_after      = bug;
        submit         = 1'b0;
        step();
    endtask

    task automatic enter_pin(input logic [3:0] d0, input logic [3:0] d1,
                             input logic [3:0] d2, input logic [3:0] d3);
        press(d0);
        press(d1);
        press(d2);
        press(d3);
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        reset          = 1'b0;
        submit         = 1'b0;
        digit_switches = 4'b0000;
        bug_after      = 1'b0;
        do_reset();

        // reset state
        chk("rst_waiting",   32'(waiting),     32'd1);
        chk("rst_correct",   32'(correct),     32'd0);
        chk("rst_incorrect", 32'(incorrect),   32'd0);
        chk("rst_locked",    32'(locked),      32'd0);
        chk("rst_bug",       32'(bug),         32'd0);
        chk("rst_count",     32'(digit_count), 32'd0);
        chk("rst_attempts",  32'(attempts),    32'd0);

        // correct PIN, result held for 4 cycles
        enter_pin(4'b1000, 4'b0100, 4'b0010, 4'b0001);
        chk("ok_password", 32'(dut.pinchk.password), 32'hE4);
        chk("ok_correct",  32'(correct),  32'd1);
        chk("ok_attempts", 32'(attempts), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ok_hold", 32'(correct), 32'd1);
        end
        step();
        chk("ok_end_correct", 32'(correct),     32'd0);
        chk("ok_end_waiting", 32'(waiting),     32'd1);
        chk("ok_end_count",   32'(digit_count), 32'd0);

        // invalid digits
        press(4'b0000);
        chk("zero_bug",       32'(bug_after),   32'd1);
        chk("zero_bug_clr",   32'(bug),         32'd0);
        chk("zero_count",     32'(digit_count), 32'd0);
        press(4'b1100);
        chk("multi_bug",      32'(bug_after),   32'd1);
        chk("multi_bug_clr",  32'(bug),         32'd0);
        chk("multi_count",    32'(digit_count), 32'd0);
        chk("multi_waiting",  32'(waiting),     32'd1);
        press(4'b1000);
        chk("valid_bug",      32'(bug_after),   32'd0);
        chk("valid_count",    32'(digit_count), 32'd1);

        // held submit enters one digit
        do_reset();
        digit_switches = 4'b1000;
        submit         = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("held_count", 32'(digit_count), 32'd1);
        submit = 1'b0;
        step();
        chk("held_count_after", 32'(digit_count), 32'd1);

        // wrong then correct
        do_reset();
        enter_pin(4'b0001, 4'b0001, 4'b0001, 4'b0001);
        chk("wc_incorrect", 32'(incorrect), 32'd1);
        chk("wc_attempts1", 32'(attempts),  32'd1);
        for (int i = 0; i < 4; i++) step();
        chk("wc_waiting", 32'(waiting), 32'd1);
        enter_pin(4'b1000, 4'b0100, 4'b0010, 4'b0001);
        chk("wc_correct",   32'(correct),  32'd1);
        chk("wc_attempts0", 32'(attempts), 32'd0);

        // lockout after three misses
        do_reset();
        enter_pin(4'b0001, 4'b0001, 4'b0001, 4'b0001);
        chk("lk_incorrect1", 32'(incorrect), 32'd1);
        chk("lk_attempts1",  32'(attempts),  32'd1);
        for (int i = 0; i < 4; i++) step();
        enter_pin(4'b0001, 4'b0001, 4'b0001, 4'b0001);
        chk("lk_incorrect2", 32'(incorrect), 32'd1);
        chk("lk_attempts2",  32'(attempts),  32'd2);
        for (int i = 0; i < 4; i++) step();
        enter_pin(4'b0001, 4'b0001, 4'b0001, 4'b0001);
        chk("lk_locked",     32'(locked),    32'd1);
        chk("lk_incorrect3", 32'(incorrect), 32'd0);
        chk("lk_attempts3",  32'(attempts),  32'd3);
        lock_cycles = 1;
        press(4'b1000);
        if (locked) lock_cycles += 2;
        chk("lk_ignore_count", 32'(digit_count), 32'd0);
        chk("lk_ignore_bug",   32'(bug_after),   32'd0);
        chk("lk_still",        32'(locked),      32'd1);
`ifdef DEBIT_PIN_LOCKOUT_TIMER_EN
        while (locked && lock_cycles < 2000) begin
            step();
            if (locked) lock_cycles++;
        end
        chk("lk_duration",    32'(lock_cycles), 32'd1000);
        chk("lk_attempts_clr", 32'(attempts),   32'd0);
        chk("lk_exit_waiting", 32'(waiting),    32'd1);
`else
        for (int i = 0; i < 50; i++) step();
        chk("lk_persist", 32'(locked),   32'd1);
        chk("lk_persist_att", 32'(attempts), 32'd3);
`endif
        do_reset();
        chk("lk_reset_locked",   32'(locked),   32'd0);
        chk("lk_reset_attempts", 32'(attempts), 32'd0);

        // reset mid-entry with submit held high
        press(4'b1000);
        press(4'b0100);
        chk("mid_count2", 32'(digit_count), 32'd2);
        digit_switches = 4'b0010;
        submit         = 1'b1;
        reset          = 1'b0;
        step();
        chk("mid_rst_count",   32'(digit_count), 32'd0);
        chk("mid_rst_waiting", 32'(waiting),     32'd1);
        reset = 1'b1;
        step();
        step();
        chk("mid_no_edge", 32'(digit_count), 32'd0);
        submit = 1'b0;
        step();
        submit = 1'b1;
        step();
        chk("mid_new_edge", 32'(digit_count), 32'd1);
        submit = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
